// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the DLX pipeline sequencer: FSM states and
// the per-stage control bundles selected by the output priority mux.
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_e;

    // Field order (MSB first) is the order the bundle is packed and compared in.
    typedef struct packed {
        logic pc_wr_en;
        logic if_id_wr_en;
        logic if_id_flush;
        logic id_ex_wr_en;
        logic id_ex_flush;
        logic ex_mem_wr_en;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL   = ctrl_t'(7'b1101010);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(7'b0001110);
    localparam ctrl_t CTRL_REDIRECT = ctrl_t'(7'b1111110);
    localparam ctrl_t CTRL_MEM_WAIT = ctrl_t'(7'b0000001);
    localparam ctrl_t CTRL_HALT     = ctrl_t'(7'b0010101);

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational load-use detector: flags an ID-stage source that matches the
// destination of a load currently in EX. Writes to R0 never create a hazard.
module pipeline_control_hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_mem_rd,
    output logic                      load_use
);

    logic rd_nonzero_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rd_nonzero_s = (ex_rd_addr != {REG_ADDR_WIDTH{1'b0}});
    assign rs1_hit_s    = rs1_used && (rs1_addr == ex_rd_addr);
    assign rs2_hit_s    = rs2_used && (rs2_addr == ex_rd_addr);
    assign load_use     = ex_mem_rd && rd_nonzero_s && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipeline_control.sv
// DLX 5-stage pipeline sequencer: stage enables/flushes for load-use, EX
// redirects and data-memory wait states, plus memory-timeout halt and stall count.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MEM_WAIT_MAX    = 15,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr_in,
    input  logic                       id_rs1_used_in,
    input  logic                       id_rs2_used_in,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr_in,
    input  logic                       ex_mem_rd_in,
    input  logic                       ex_branch_taken_in,
    input  logic                       ex_jmp_in,
    input  logic                       mem_req_in,
    input  logic                       mem_ack_in,
    output logic                       pc_wr_en_out,
    output logic                       if_id_wr_en_out,
    output logic                       if_id_flush_out,
    output logic                       id_ex_wr_en_out,
    output logic                       id_ex_flush_out,
    output logic                       ex_mem_wr_en_out,
    output logic                       mem_wb_flush_out,
    output logic                       halt_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_out
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [WAIT_W-1:0]          wait_cnt_r;
    logic [WAIT_W-1:0]          wait_cnt_nxt_s;
    logic                       halt_r;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;
    ctrl_t                      ctrl_s;
    logic                       load_use_s;
    logic                       mem_wait_s;
    logic                       redirect_s;

    pipeline_control_hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .rs1_addr   (id_rs1_addr_in),
        .rs2_addr   (id_rs2_addr_in),
        .rs1_used   (id_rs1_used_in),
        .rs2_used   (id_rs2_used_in),
        .ex_rd_addr (ex_rd_addr_in),
        .ex_mem_rd  (ex_mem_rd_in),
        .load_use   (load_use_s)
    );

    assign mem_wait_s = mem_req_in && !mem_ack_in;
    assign redirect_s = ex_branch_taken_in || ex_jmp_in;

    // State register and consecutive memory-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state logic; the first wait cycle is spent in RUN, so MEM_WAIT_MAX
    // counted cycles in MEM_WAIT give MEM_WAIT_MAX+1 frozen cycles before HALT.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_wait_s) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait_s) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_W'(MEM_WAIT_MAX)) begin
                    state_nxt_s    = ST_HALT;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s    = ST_HALT;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Output priority mux: HALT > memory wait > branch/jump > load-use
    always_comb begin
        ctrl_s = CTRL_HALT;
        if (rst) begin
            ctrl_s = CTRL_HALT;
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_wait_s) begin
                        ctrl_s = CTRL_MEM_WAIT;
                    end else if (redirect_s) begin
                        ctrl_s = CTRL_REDIRECT;
                    end else if (load_use_s) begin
                        ctrl_s = CTRL_LOAD_USE;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                ST_HALT: ctrl_s = CTRL_HALT;
                default: ctrl_s = CTRL_HALT;
            endcase
        end
    end

    // Sticky timeout flag, set on the edge that enters HALT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_r <= 1'b0;
        end else if (state_nxt_s == ST_HALT) begin
            halt_r <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
        end else if (!ctrl_s.pc_wr_en && (stall_cnt_r != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_WIDTH'(1);
        end
    end

    assign pc_wr_en_out     = ctrl_s.pc_wr_en;
    assign if_id_wr_en_out  = ctrl_s.if_id_wr_en;
    assign if_id_flush_out  = ctrl_s.if_id_flush;
    assign id_ex_wr_en_out  = ctrl_s.id_ex_wr_en;
    assign id_ex_flush_out  = ctrl_s.id_ex_flush;
    assign ex_mem_wr_en_out = ctrl_s.ex_mem_wr_en;
    assign mem_wb_flush_out = ctrl_s.mem_wb_flush;
    assign halt_out         = halt_r;
    assign stall_cnt_out    = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: load-use, redirects, memory waits,
// timeout halt and asynchronous reset, checked against hand-computed vectors.
module tb_pipeline_control;

    // Control vector order: {pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr, mem_wb_flush}
    localparam logic [6:0] V_NORMAL = 7'b1101010;
    localparam logic [6:0] V_LOAD   = 7'b0001110;
    localparam logic [6:0] V_REDIR  = 7'b1111110;
    localparam logic [6:0] V_MWAIT  = 7'b0000001;
    localparam logic [6:0] V_HALT   = 7'b0010101;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr_in, id_rs2_addr_in, ex_rd_addr_in;
    logic        id_rs1_used_in, id_rs2_used_in, ex_mem_rd_in;
    logic        ex_branch_taken_in, ex_jmp_in, mem_req_in, mem_ack_in;
    logic        pc_wr_en_out, if_id_wr_en_out, if_id_flush_out, id_ex_wr_en_out;
    logic        id_ex_flush_out, ex_mem_wr_en_out, mem_wb_flush_out, halt_out;
    logic [15:0] stall_cnt_out;
    logic [6:0]  ctrl;

    int asserts_n = 0;
    int fails_n   = 0;

    always #5 clk = ~clk;

    pipeline_control #(
        .REG_ADDR_WIDTH  (5),
        .MEM_WAIT_MAX    (15),
        .STALL_CNT_WIDTH (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1_addr_in     (id_rs1_addr_in),
        .id_rs2_addr_in     (id_rs2_addr_in),
        .id_rs1_used_in     (id_rs1_used_in),
        .id_rs2_used_in     (id_rs2_used_in),
        .ex_rd_addr_in      (ex_rd_addr_in),
        .ex_mem_rd_in       (ex_mem_rd_in),
        .ex_branch_taken_in (ex_branch_taken_in),
        .ex_jmp_in          (ex_jmp_in),
        .mem_req_in         (mem_req_in),
        .mem_ack_in         (mem_ack_in),
        .pc_wr_en_out       (pc_wr_en_out),
        .if_id_wr_en_out    (if_id_wr_en_out),
        .if_id_flush_out    (if_id_flush_out),
        .id_ex_wr_en_out    (id_ex_wr_en_out),
        .id_ex_flush_out    (id_ex_flush_out),
        .ex_mem_wr_en_out   (ex_mem_wr_en_out),
        .mem_wb_flush_out   (mem_wb_flush_out),
        .halt_out           (halt_out),
        .stall_cnt_out      (stall_cnt_out)
    );

    assign ctrl = {pc_wr_en_out, if_id_wr_en_out, if_id_flush_out, id_ex_wr_en_out,
                   id_ex_flush_out, ex_mem_wr_en_out, mem_wb_flush_out};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        asserts_n++;
        assert (obs === expv)
        else begin
            fails_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic ld, input logic br, input logic jmp,
                         input logic req, input logic ack);
        id_rs1_addr_in     = rs1;
        id_rs1_used_in     = u1;
        id_rs2_addr_in     = rs2;
        id_rs2_used_in     = u2;
        ex_rd_addr_in      = rd;
        ex_mem_rd_in       = ld;
        ex_branch_taken_in = br;
        ex_jmp_in          = jmp;
        mem_req_in         = req;
        mem_ack_in         = ack;
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_ctrl", 32'(ctrl), 32'(V_HALT));
        check("reset_halt", 32'(halt_out), 32'd0);
        check("reset_stall", 32'(stall_cnt_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle", 32'(ctrl), 32'(V_NORMAL));
        tick();
        check("idle_stall", 32'(stall_cnt_out), 32'd0);

        // lw r3 in EX, add r4,r3,r1 in ID
        drive(5'd3, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_use", 32'(ctrl), 32'(V_LOAD));
        tick();
        check("load_use_stall", 32'(stall_cnt_out), 32'd1);
        drive(5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_bubble", 32'(ctrl), 32'(V_NORMAL));
        tick();
        check("after_bubble_stall", 32'(stall_cnt_out), 32'd1);

        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_r0", 32'(ctrl), 32'(V_NORMAL));
        tick();
        drive(5'd2, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rs2_unused", 32'(ctrl), 32'(V_NORMAL));
        tick();
        drive(5'd2, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rs2_hit", 32'(ctrl), 32'(V_LOAD));
        tick();
        check("rs2_hit_stall", 32'(stall_cnt_out), 32'd2);

        drive(5'd2, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("branch_over_load", 32'(ctrl), 32'(V_REDIR));
        tick();
        drive(5'd2, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("jump", 32'(ctrl), 32'(V_REDIR));
        tick();
        check("redirect_stall", 32'(stall_cnt_out), 32'd2);

        // asynchronous reset clears the counter without a clock edge
        rst = 1'b1;
        #1;
        check("async_rst_stall", 32'(stall_cnt_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // three-cycle memory wait with a taken branch held in EX
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mem_wait_%0d", i), 32'(ctrl), 32'(V_MWAIT));
            tick();
        end
        check("mem_wait_stall", 32'(stall_cnt_out), 32'd3);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ack_branch", 32'(ctrl), 32'(V_REDIR));
        tick();
        check("ack_stall", 32'(stall_cnt_out), 32'd3);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("resume", 32'(ctrl), 32'(V_NORMAL));
        tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ack_first_cycle", 32'(ctrl), 32'(V_NORMAL));
        tick();
        check("ack_first_stall", 32'(stall_cnt_out), 32'd3);

        // memory never acks: 16 frozen cycles, then HALT
        pulse_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("timeout_ctrl_%0d", i), 32'(ctrl), 32'(V_MWAIT));
            check($sformatf("timeout_halt_%0d", i), 32'(halt_out), 32'd0);
            tick();
        end
        check("halt_set", 32'(halt_out), 32'd1);
        check("halt_ctrl", 32'(ctrl), 32'(V_HALT));
        check("halt_stall", 32'(stall_cnt_out), 32'd16);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halt_held_ctrl", 32'(ctrl), 32'(V_HALT));
        tick();
        check("halt_held", 32'(halt_out), 32'd1);
        check("halt_stall_inc", 32'(stall_cnt_out), 32'd17);

        // async reset out of HALT
        rst = 1'b1;
        #1;
        check("rst_halt_clr", 32'(halt_out), 32'd0);
        check("rst_halt_stall", 32'(stall_cnt_out), 32'd0);
        check("rst_halt_ctrl", 32'(ctrl), 32'(V_HALT));
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_halt_run", 32'(ctrl), 32'(V_NORMAL));

        // async reset in the middle of a memory wait
        tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("mid_wait_stall", 32'(stall_cnt_out), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_wait_rst_stall", 32'(stall_cnt_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_wait_resume", 32'(ctrl), 32'(V_NORMAL));
        tick();
        check("mid_wait_no_halt", 32'(halt_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
        $finish;
    end

endmodule
